// File: rtl/encoder_rreq_scheduler.sv
// ---------------------------------------------------------------------------
// encoder_rreq_scheduler
//
// Purpose:
//   Shares the encoder's single memory read-request channel between
//   cover-image bursts (which fill the cimg input FIFO) and message bursts
//   (which fill the msg input FIFO). Each start pulse runs one frame.
//   A message burst goes out first so the message FSM has a word before
//   pixels flow. After that, one message burst follows every
//   NUM_CIMG_RREQS_PER_MSG_RREQ image bursts. No message burst follows the
//   final image burst. The block limits the number of accepted-but-incomplete
//   bursts and reports frame completion once every burst has returned.
//
// Ports:
//   encoder_clk             clock
//   encoder_reset           synchronous active-high reset
//   start                   pulse, begins a frame (ignored while busy)
//   cimg_base_addr[31:0]    image base address, sampled on accepted start
//   msg_base_addr[31:0]     message base address, sampled on accepted start
//   cimg_infifo_can_accept  cimg FIFO has room for one image burst
//   msg_infifo_can_accept   msg FIFO has room for one message burst
//   rreq_ready              memory accepts the current request
//   rdata_last              pulse, last beat of some burst returned
//   rreq_valid              request valid
//   rreq_addr[31:0]         request byte address
//   rreq_len[7:0]           request length in beats minus one
//   rreq_is_msg             1 = message burst, 0 = image burst
//   busy                    frame in progress
//   frame_done              one-cycle pulse when the frame completes
//   err_rlast_underflow     sticky, rdata_last seen with nothing outstanding
// ---------------------------------------------------------------------------
module encoder_rreq_scheduler #(
    parameter int IMG_RBURST_LEN              = 128,
    parameter int MSG_RBURST_LEN              = 16,
    parameter int NUM_RREQS_PER_CIMG          = 7200,
    parameter int NUM_CIMG_RREQS_PER_MSG_RREQ = 512,
    parameter int BEAT_BYTES                  = 4,
    parameter int MAX_OUTSTANDING             = 4
) (
    input  logic        encoder_clk,
    input  logic        encoder_reset,
    input  logic        start,
    input  logic [31:0] cimg_base_addr,
    input  logic [31:0] msg_base_addr,
    input  logic        cimg_infifo_can_accept,
    input  logic        msg_infifo_can_accept,
    input  logic        rreq_ready,
    input  logic        rdata_last,
    output logic        rreq_valid,
    output logic [31:0] rreq_addr,
    output logic [7:0]  rreq_len,
    output logic        rreq_is_msg,
    output logic        busy,
    output logic        frame_done,
    output logic        err_rlast_underflow
);

    localparam int IMG_CW   = $clog2(NUM_RREQS_PER_CIMG + 1);
    localparam int SINCE_CW = $clog2(NUM_CIMG_RREQS_PER_MSG_RREQ + 1);
    localparam int OUT_CW   = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [IMG_CW-1:0]   IMG_TOTAL   = IMG_CW'(NUM_RREQS_PER_CIMG);
    localparam logic [SINCE_CW-1:0] IMG_PER_MSG = SINCE_CW'(NUM_CIMG_RREQS_PER_MSG_RREQ);
    localparam logic [OUT_CW-1:0]   OUT_MAX     = OUT_CW'(MAX_OUTSTANDING);
    localparam logic [31:0]         IMG_STRIDE  = 32'(IMG_RBURST_LEN * BEAT_BYTES);
    localparam logic [31:0]         MSG_STRIDE  = 32'(MSG_RBURST_LEN * BEAT_BYTES);
    localparam logic [7:0]          IMG_LEN     = 8'(IMG_RBURST_LEN - 1);
    localparam logic [7:0]          MSG_LEN     = 8'(MSG_RBURST_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARB,
        S_ISSUE,
        S_DRAIN
    } state_e;

    state_e              state_q,         state_d;
    logic [31:0]         cimg_addr_q,     cimg_addr_d;
    logic [31:0]         msg_addr_q,      msg_addr_d;
    logic [IMG_CW-1:0]   img_issued_q,    img_issued_d;
    logic [SINCE_CW-1:0] img_since_msg_q, img_since_msg_d;
    logic                msg_pending_q,   msg_pending_d;
    logic [31:0]         req_addr_q,      req_addr_d;
    logic [7:0]          req_len_q,       req_len_d;
    logic                req_is_msg_q,    req_is_msg_d;
    logic [OUT_CW-1:0]   outstanding_q,   outstanding_d;
    logic                err_q,           err_d;

    logic                handshake;
    logic                slot_free;
    logic                img_left;
    logic [IMG_CW-1:0]   img_issued_inc;
    logic [SINCE_CW-1:0] img_since_inc;

    assign handshake      = (state_q == S_ISSUE) && rreq_ready;
    assign slot_free      = (outstanding_q < OUT_MAX);
    assign img_left       = (img_issued_q < IMG_TOTAL);
    assign img_issued_inc = img_issued_q + 1'b1;
    assign img_since_inc  = img_since_msg_q + 1'b1;

    // Frame sequencing and arbitration. A pending message burst blocks image
    // bursts so that message data always lands ahead of the image data that
    // follows it. The request fields are captured on the arbitration decision.
    // They then stay frozen through ISSUE, which keeps the channel stable
    // while the memory stalls.
    always_comb begin
        state_d         = state_q;
        cimg_addr_d     = cimg_addr_q;
        msg_addr_d      = msg_addr_q;
        img_issued_d    = img_issued_q;
        img_since_msg_d = img_since_msg_q;
        msg_pending_d   = msg_pending_q;
        req_addr_d      = req_addr_q;
        req_len_d       = req_len_q;
        req_is_msg_d    = req_is_msg_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cimg_addr_d     = cimg_base_addr;
                    msg_addr_d      = msg_base_addr;
                    img_issued_d    = '0;
                    img_since_msg_d = '0;
                    msg_pending_d   = 1'b1;
                    state_d         = S_ARB;
                end
            end

            S_ARB: begin
                if (msg_pending_q && msg_infifo_can_accept && slot_free) begin
                    req_addr_d   = msg_addr_q;
                    req_len_d    = MSG_LEN;
                    req_is_msg_d = 1'b1;
                    state_d      = S_ISSUE;
                end else if (img_left && !msg_pending_q && cimg_infifo_can_accept && slot_free) begin
                    req_addr_d   = cimg_addr_q;
                    req_len_d    = IMG_LEN;
                    req_is_msg_d = 1'b0;
                    state_d      = S_ISSUE;
                end else if (!img_left && !msg_pending_q) begin
                    state_d = S_DRAIN;
                end
            end

            // A message burst is scheduled only when more image bursts
            // remain. When the last image burst lands on an exact multiple,
            // the frame ends without a trailing message burst.
            S_ISSUE: begin
                if (rreq_ready) begin
                    state_d = S_ARB;
                    if (req_is_msg_q) begin
                        msg_addr_d    = msg_addr_q + MSG_STRIDE;
                        msg_pending_d = 1'b0;
                    end else begin
                        cimg_addr_d  = cimg_addr_q + IMG_STRIDE;
                        img_issued_d = img_issued_inc;
                        if ((img_since_inc == IMG_PER_MSG) && (img_issued_inc < IMG_TOTAL)) begin
                            msg_pending_d   = 1'b1;
                            img_since_msg_d = '0;
                        end else begin
                            img_since_msg_d = img_since_inc;
                        end
                    end
                end
            end

            S_DRAIN: begin
                if (outstanding_q == '0) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outstanding-burst tracking. An acceptance and a completion in the same
    // cycle cancel out. A completion with nothing outstanding cannot belong
    // to any burst of this block. In that case the counter does not wrap,
    // and the sticky error flag is raised instead.
    always_comb begin
        outstanding_d = outstanding_q;
        err_d         = err_q;
        if (rdata_last && (outstanding_q == '0)) begin
            err_d         = 1'b1;
            outstanding_d = handshake ? OUT_CW'(1) : '0;
        end else begin
            case ({handshake, rdata_last})
                2'b10:   outstanding_d = outstanding_q + 1'b1;
                2'b01:   outstanding_d = outstanding_q - 1'b1;
                default: outstanding_d = outstanding_q;
            endcase
        end
    end

    // State register. Reset aborts any frame in flight immediately and
    // produces no completion pulse.
    always_ff @(posedge encoder_clk) begin
        if (encoder_reset) begin
            state_q         <= S_IDLE;
            cimg_addr_q     <= '0;
            msg_addr_q      <= '0;
            img_issued_q    <= '0;
            img_since_msg_q <= '0;
            msg_pending_q   <= 1'b0;
            req_addr_q      <= '0;
            req_len_q       <= '0;
            req_is_msg_q    <= 1'b0;
            outstanding_q   <= '0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            cimg_addr_q     <= cimg_addr_d;
            msg_addr_q      <= msg_addr_d;
            img_issued_q    <= img_issued_d;
            img_since_msg_q <= img_since_msg_d;
            msg_pending_q   <= msg_pending_d;
            req_addr_q      <= req_addr_d;
            req_len_q       <= req_len_d;
            req_is_msg_q    <= req_is_msg_d;
            outstanding_q   <= outstanding_d;
            err_q           <= err_d;
        end
    end

    assign rreq_valid          = (state_q == S_ISSUE);
    assign rreq_addr           = req_addr_q;
    assign rreq_len            = req_len_q;
    assign rreq_is_msg         = req_is_msg_q;
    assign busy                = (state_q != S_IDLE);
    assign frame_done          = (state_q == S_DRAIN) && (outstanding_q == '0);
    assign err_rlast_underflow = err_q;

endmodule

// File: tb/tb_encoder_rreq_scheduler.sv
// ---------------------------------------------------------------------------
// tb_encoder_rreq_scheduler
//
// Purpose:
//   Self-checking bench for encoder_rreq_scheduler. It uses two instances
//   that share every input:
//     dutA  6 image bursts per frame, message burst every 4 image bursts
//     dutB  8 image bursts per frame, message burst every 4 image bursts
//   The useB variable selects which instance's outputs the bench observes.
//   Both instances are reset before the bench switches between them.
//
//   A reference model builds the expected request list for each frame from
//   the frame rules, using plain address arithmetic. Accepted requests are
//   compared in order against that list. The model also counts outstanding
//   bursts as completions are fed back.
// ---------------------------------------------------------------------------
module tb_encoder_rreq_scheduler;

    localparam int          MAX_OUT    = 4;
    localparam logic [31:0] IMG_STRIDE = 32'd512;
    localparam logic [31:0] MSG_STRIDE = 32'd64;
    localparam logic [7:0]  IMG_LEN    = 8'd127;
    localparam logic [7:0]  MSG_LEN    = 8'd15;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] cimgBase;
    logic [31:0] msgBase;
    logic        cimgOk;
    logic        msgOk;
    logic        ready;
    logic        rlast;

    logic        aValid, aIsMsg, aBusy, aDone, aErr;
    logic [31:0] aAddr;
    logic [7:0]  aLen;
    logic        bValid, bIsMsg, bBusy, bDone, bErr;
    logic [31:0] bAddr;
    logic [7:0]  bLen;

    logic        valid, isMsg, busy, done, err;
    logic [31:0] addr;
    logic [7:0]  len;
    bit          useB;

    int errors;
    int checks;

    encoder_rreq_scheduler #(
        .NUM_RREQS_PER_CIMG(6),
        .NUM_CIMG_RREQS_PER_MSG_RREQ(4)
    ) dutA (
        .encoder_clk(clk),
        .encoder_reset(rst),
        .start(start),
        .cimg_base_addr(cimgBase),
        .msg_base_addr(msgBase),
        .cimg_infifo_can_accept(cimgOk),
        .msg_infifo_can_accept(msgOk),
        .rreq_ready(ready),
        .rdata_last(rlast),
        .rreq_valid(aValid),
        .rreq_addr(aAddr),
        .rreq_len(aLen),
        .rreq_is_msg(aIsMsg),
        .busy(aBusy),
        .frame_done(aDone),
        .err_rlast_underflow(aErr)
    );

    encoder_rreq_scheduler #(
        .NUM_RREQS_PER_CIMG(8),
        .NUM_CIMG_RREQS_PER_MSG_RREQ(4)
    ) dutB (
        .encoder_clk(clk),
        .encoder_reset(rst),
        .start(start),
        .cimg_base_addr(cimgBase),
        .msg_base_addr(msgBase),
        .cimg_infifo_can_accept(cimgOk),
        .msg_infifo_can_accept(msgOk),
        .rreq_ready(ready),
        .rdata_last(rlast),
        .rreq_valid(bValid),
        .rreq_addr(bAddr),
        .rreq_len(bLen),
        .rreq_is_msg(bIsMsg),
        .busy(bBusy),
        .frame_done(bDone),
        .err_rlast_underflow(bErr)
    );

    // Output selection between the two instances.
    always_comb begin
        valid = useB ? bValid : aValid;
        addr  = useB ? bAddr  : aAddr;
        len   = useB ? bLen   : aLen;
        isMsg = useB ? bIsMsg : aIsMsg;
        busy  = useB ? bBusy  : aBusy;
        done  = useB ? bDone  : aDone;
        err   = useB ? bErr   : aErr;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous reset held for two edges, with all inputs idle.
    task automatic applyReset();
        @(negedge clk);
        rst      = 1'b1;
        start    = 1'b0;
        rlast    = 1'b0;
        ready    = 1'b0;
        cimgOk   = 1'b1;
        msgOk    = 1'b1;
        cimgBase = 32'h0;
        msgBase  = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Runs one frame on the selected instance and checks every accepted
    // request against the model's ordered list. Completions come back
    // 3 cycles after acceptance, or after a random delay when rnd is set.
    task automatic run_frame(input string tag, input logic [31:0] cb, input logic [31:0] mb,
                             input int nImg, input int perMsg, input bit rnd, output int msgSeen);
        logic [31:0] expAddr[$];
        bit          expMsg[$];
        int          dueQ[$];
        logic [31:0] ma;
        logic [31:0] pAddr;
        logic [7:0]  pLen;
        logic [7:0]  eLen;
        logic        pMsg;
        bit          pend;
        int          outst, got, dones, lastDue, doneCyc, due;

        ma = mb;
        expAddr.push_back(ma);
        expMsg.push_back(1'b1);
        ma = ma + MSG_STRIDE;
        for (int i = 1; i <= nImg; i++) begin
            expAddr.push_back(cb + 32'(i - 1) * IMG_STRIDE);
            expMsg.push_back(1'b0);
            if ((i % perMsg == 0) && (i < nImg)) begin
                expAddr.push_back(ma);
                expMsg.push_back(1'b1);
                ma = ma + MSG_STRIDE;
            end
        end

        outst = 0; got = 0; dones = 0; lastDue = 0; doneCyc = -1;
        pend = 1'b0; pAddr = '0; pLen = '0; pMsg = 1'b0; msgSeen = 0;

        @(negedge clk);
        cimgBase = cb; msgBase = mb; start = 1'b1;
        ready = 1'b1; cimgOk = 1'b1; msgOk = 1'b1; rlast = 1'b0;
        @(negedge clk);
        start = 1'b0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (pend) begin
                checks++;
                if (valid !== 1'b1 || addr !== pAddr || len !== pLen || isMsg !== pMsg) begin
                    errors++;
                    $display("[TB] FAIL %s stall_hold: valid=%b addr=%h len=%0d msg=%b, need valid=1 addr=%h len=%0d msg=%b",
                             tag, valid, addr, len, isMsg, pAddr, pLen, pMsg);
                end
            end
            if (done === 1'b1) begin
                dones++;
                if (doneCyc < 0) begin
                    doneCyc = cyc;
                    checks++;
                    if (got != expAddr.size() || outst != 0) begin
                        errors++;
                        $display("[TB] FAIL %s done_early: accepted=%0d outstanding=%0d, need accepted=%0d outstanding=0",
                                 tag, got, outst, expAddr.size());
                    end
                end
            end
            if (doneCyc >= 0 && cyc >= doneCyc + 3) break;

            if (rnd) begin
                ready  = ($urandom % 4) != 0;
                cimgOk = ($urandom % 4) != 0;
                msgOk  = ($urandom % 4) != 0;
            end

            if (valid === 1'b1 && ready) begin
                checks++;
                if (got >= expAddr.size()) begin
                    errors++;
                    $display("[TB] FAIL %s extra_request: got addr=%h msg=%b, need no further request", tag, addr, isMsg);
                end else begin
                    eLen = expMsg[got] ? MSG_LEN : IMG_LEN;
                    if (addr !== expAddr[got] || isMsg !== expMsg[got] || len !== eLen) begin
                        errors++;
                        $display("[TB] FAIL %s order[%0d]: got addr=%h msg=%b len=%0d, need addr=%h msg=%b len=%0d",
                                 tag, got, addr, isMsg, len, expAddr[got], expMsg[got], eLen);
                    end
                end
                checks++;
                if (outst >= MAX_OUT) begin
                    errors++;
                    $display("[TB] FAIL %s outstanding_limit: accepted with %0d outstanding, need < %0d", tag, outst, MAX_OUT);
                end
                if (isMsg === 1'b1) msgSeen++;
                got++;
                outst++;
                due = cyc + (rnd ? int'($urandom_range(1, 8)) : 3);
                if (due <= lastDue) due = lastDue + 1;
                lastDue = due;
                dueQ.push_back(due);
            end

            rlast = 1'b0;
            if (dueQ.size() > 0 && dueQ[0] <= cyc) begin
                rlast = 1'b1;
                void'(dueQ.pop_front());
                outst--;
            end

            pend  = (valid === 1'b1) && !ready;
            pAddr = addr; pLen = len; pMsg = isMsg;
            @(negedge clk);
        end
        rlast = 1'b0; ready = 1'b1; cimgOk = 1'b1; msgOk = 1'b1;

        checks++;
        if (dones != 1) begin
            errors++;
            $display("[TB] FAIL %s done_pulses: got %0d, need 1", tag, dones);
        end
        checks++;
        if (got != expAddr.size()) begin
            errors++;
            $display("[TB] FAIL %s request_count: got %0d, need %0d", tag, got, expAddr.size());
        end
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s idle_after: busy=%b valid=%b, need 0 0", tag, busy, valid);
        end
    endtask

    task automatic test_reset();
        useB = 1'b0;
        applyReset();
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: valid=%b busy=%b done=%b err=%b, need all 0", valid, busy, done, err);
        end
        checks++;
        if (addr !== 32'h0 || len !== 8'h0 || isMsg !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_req: addr=%h len=%0d msg=%b, need 0", addr, len, isMsg);
        end
    endtask

    task automatic test_basic_order();
        int m;
        useB = 1'b0;
        applyReset();
        run_frame("basic", 32'h1000, 32'h8000, 6, 4, 1'b0, m);
        checks++;
        if (m != 2) begin
            errors++;
            $display("[TB] FAIL basic msg_count: got %0d, need 2", m);
        end
    endtask

    task automatic test_exact_multiple();
        int m;
        useB = 1'b1;
        applyReset();
        run_frame("exact", 32'h2000, 32'h9000, 8, 4, 1'b0, m);
        checks++;
        if (m != 2) begin
            errors++;
            $display("[TB] FAIL exact msg_count: got %0d, need 2", m);
        end
        useB = 1'b0;
        applyReset();
    endtask

    task automatic test_stall();
        int w;
        logic [31:0] sAddr;
        logic [7:0]  sLen;
        logic        sMsg;
        useB = 1'b0;
        applyReset();
        cimgBase = 32'h1000; msgBase = 32'h8000; ready = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (w = 0; w < 10 && valid !== 1'b1; w++) @(negedge clk);
        checks++;
        if (valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_wait: valid=%b, need 1 within 10 cycles", valid);
        end
        sAddr = addr; sLen = len; sMsg = isMsg;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (valid !== 1'b1 || addr !== sAddr || len !== sLen || isMsg !== sMsg) begin
                errors++;
                $display("[TB] FAIL stall_hold[%0d]: valid=%b addr=%h len=%0d msg=%b, need 1 %h %0d %b",
                         i, valid, addr, len, isMsg, sAddr, sLen, sMsg);
            end
        end
        checks++;
        if (sAddr !== 32'h8000 || sMsg !== 1'b1 || sLen !== MSG_LEN) begin
            errors++;
            $display("[TB] FAIL stall_first: addr=%h msg=%b len=%0d, need 00008000 1 15", sAddr, sMsg, sLen);
        end
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_single_accept: valid=%b after accept, need 0", valid);
        end
        applyReset();
    endtask

    task automatic test_outstanding();
        int acc, w;
        useB = 1'b0;
        applyReset();
        cimgBase = 32'h1000; msgBase = 32'h8000; ready = 1'b1; rlast = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        acc = 0;
        repeat (30) begin
            if (valid === 1'b1 && ready) acc++;
            @(negedge clk);
        end
        checks++;
        if (acc != 4 || valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL outst_limit: accepts=%0d valid=%b, need 4 0", acc, valid);
        end
        rlast = 1'b1;
        @(negedge clk);
        rlast = 1'b0;
        acc = 0;
        repeat (15) begin
            if (valid === 1'b1 && ready) acc++;
            @(negedge clk);
        end
        checks++;
        if (acc != 1 || valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL outst_one_free: accepts=%0d valid=%b, need 1 0", acc, valid);
        end
        ready = 1'b0;
        rlast = 1'b1;
        @(negedge clk);
        rlast = 1'b0;
        for (w = 0; w < 10 && valid !== 1'b1; w++) @(negedge clk);
        checks++;
        if (valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL outst_wait: valid=%b, need 1 within 10 cycles", valid);
        end
        ready = 1'b1;
        rlast = 1'b1;
        @(negedge clk);
        rlast = 1'b0;
        acc = 0;
        repeat (15) begin
            if (valid === 1'b1 && ready) acc++;
            @(negedge clk);
        end
        checks++;
        if (acc != 1 || valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL outst_coincide: accepts=%0d valid=%b, need 1 0", acc, valid);
        end
        applyReset();
    endtask

    task automatic test_msg_block();
        int seen, w;
        useB = 1'b0;
        applyReset();
        cimgBase = 32'h1000; msgBase = 32'h8000; ready = 1'b1; msgOk = 1'b0; cimgOk = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        repeat (20) begin
            if (valid === 1'b1) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("[TB] FAIL msg_block: valid cycles=%0d, need 0", seen);
        end
        msgOk = 1'b1;
        for (w = 0; w < 10 && valid !== 1'b1; w++) @(negedge clk);
        checks++;
        if (valid !== 1'b1 || isMsg !== 1'b1 || addr !== 32'h8000) begin
            errors++;
            $display("[TB] FAIL msg_first: valid=%b msg=%b addr=%h, need 1 1 00008000", valid, isMsg, addr);
        end
        applyReset();
    endtask

    task automatic test_reset_mid();
        int w, m, seenDone;
        useB = 1'b0;
        applyReset();
        cimgBase = 32'h1000; msgBase = 32'h8000; ready = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (w = 0; w < 10 && valid !== 1'b1; w++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid: valid=%b busy=%b done=%b, need 0 0 0", valid, busy, done);
        end
        rst = 1'b0;
        seenDone = 0;
        repeat (5) begin
            if (done === 1'b1) seenDone++;
            @(negedge clk);
        end
        checks++;
        if (seenDone != 0) begin
            errors++;
            $display("[TB] FAIL reset_mid_done: pulses=%0d, need 0", seenDone);
        end
        run_frame("restart", 32'h1000, 32'h8000, 6, 4, 1'b0, m);
    endtask

    task automatic test_underflow();
        useB = 1'b0;
        applyReset();
        rlast = 1'b1;
        @(negedge clk);
        rlast = 1'b0;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL underflow_set: err=%b, need 1", err);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL underflow_sticky: err=%b, need 1", err);
        end
        applyReset();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL underflow_clear: err=%b, need 0", err);
        end
    endtask

    task automatic test_random_frames();
        int m;
        useB = 1'b0;
        applyReset();
        run_frame("wrapA", 32'hFFFF_FC00, 32'hFFFF_FFC0, 6, 4, 1'b1, m);
        for (int k = 0; k < 3; k++) begin
            run_frame("randA", $urandom, $urandom, 6, 4, 1'b1, m);
        end
        useB = 1'b1;
        applyReset();
        for (int k = 0; k < 2; k++) begin
            run_frame("randB", $urandom, $urandom, 8, 4, 1'b1, m);
        end
        useB = 1'b0;
        applyReset();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        useB   = 1'b0;
        rst = 1'b1; start = 1'b0; rlast = 1'b0; ready = 1'b0;
        cimgOk = 1'b1; msgOk = 1'b1; cimgBase = '0; msgBase = '0;
        test_reset();
        test_basic_order();
        test_exact_multiple();
        test_stall();
        test_outstanding();
        test_msg_block();
        test_reset_mid();
        test_underflow();
        test_random_frames();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/encoder_rreq_scheduler.md
Name: encoder_rreq_scheduler

Overview:
Sequences and arbitrates the encoder's single memory read-request channel between cover-image bursts (feeding the cimg input FIFO) and message bursts (feeding the msg input FIFO) for one frame per start pulse. It issues one msg burst at frame start, so the message FSM has a word before pixels flow. It then issues a further msg burst after every NUM_CIMG_RREQS_PER_MSG_RREQ image bursts. It bounds outstanding bursts, tracks burst completion and signals frame completion.

Parameters:
IMG_RBURST_LEN, 128, beats per cover-image burst
MSG_RBURST_LEN, 16, beats per message burst
NUM_RREQS_PER_CIMG, 7200, image bursts per frame
NUM_CIMG_RREQS_PER_MSG_RREQ, 512, image bursts between msg bursts
BEAT_BYTES, 4, bytes per beat (address stride unit)
MAX_OUTSTANDING, 4, max accepted-but-incomplete bursts

Ports:
encoder_clk  in  1  clock
encoder_reset  in  1  synchronous active-high reset
start  in  1  pulse; begin frame (ignored while busy)
cimg_base_addr  in  32  frame image base, sampled on accepted start
msg_base_addr  in  32  message base, sampled on accepted start
cimg_infifo_can_accept  in  1  cimg FIFO has room for one IMG burst
msg_infifo_can_accept  in  1  msg FIFO has room for one MSG burst
rreq_ready  in  1  memory accepts request
rdata_last  in  1  pulse; final beat of some burst returned
rreq_valid  out  1  request valid
rreq_addr  out  32  byte address
rreq_len  out  8  beats-1
rreq_is_msg  out  1  1=msg burst, 0=image burst
busy  out  1  frame in progress
frame_done  out  1  one-cycle completion pulse
err_rlast_underflow  out  1  sticky; rdata_last with zero outstanding

Behaviour:
- Reset: all outputs 0; state IDLE; counters, outstanding count and msg_pending cleared. Reset mid-frame aborts immediately; returns to IDLE with no frame_done pulse.
- States: IDLE, ARB, ISSUE, DRAIN.
- IDLE: on start, latch both base addresses into cimg_addr and msg_addr, clear img_issued and img_since_msg, set msg_pending=1, busy=1, go to ARB.
- ARB: eligible only if outstanding < MAX_OUTSTANDING.
  - Priority 1, msg: msg_pending && msg_infifo_can_accept.
  - Priority 2, image: img_issued < NUM_RREQS_PER_CIMG && !msg_pending && cimg_infifo_can_accept. Image is blocked while a msg is pending, to preserve ordering.
  - On a decision, register addr, len and is_msg; go to ISSUE. rreq_valid is asserted the following cycle.
  - If all image bursts are issued and msg_pending=0, go to DRAIN.
- ISSUE: rreq_valid=1; addr, len and is_msg held stable until rreq_ready.
  - On handshake: rreq_valid=0 next cycle; outstanding++.
  - Msg handshake: msg_addr += MSG_RBURST_LEN*BEAT_BYTES; msg_pending=0.
  - Image handshake: cimg_addr += IMG_RBURST_LEN*BEAT_BYTES; img_issued++, img_since_msg++.
  - If img_since_msg reaches NUM_CIMG_RREQS_PER_MSG_RREQ and img_issued < NUM_RREQS_PER_CIMG: set msg_pending and reset img_since_msg to 0. At an exact final multiple, no msg is issued.
  - Return to ARB. Minimum request spacing is 2 cycles.
- rreq_len = IMG_RBURST_LEN-1 or MSG_RBURST_LEN-1.
- Outstanding counter: rdata_last decrements it; a handshake and rdata_last in the same cycle leave it unchanged. rdata_last at zero leaves it at 0 and sets err_rlast_underflow, which clears only on reset.
- DRAIN: when outstanding==0, assert frame_done for one cycle, busy=0, go to IDLE. A start in that same cycle is ignored.
- Msg bursts per frame = 1 + floor((NUM_RREQS_PER_CIMG-1)/NUM_CIMG_RREQS_PER_MSG_RREQ), i.e. 15 at defaults.
- Addresses wrap modulo 2^32.

Test Plan:
- NUM_RREQS_PER_CIMG=6, NUM_CIMG_RREQS_PER_MSG_RREQ=4, bases 0x1000/0x8000, rreq_ready tied 1, rdata_last 3 cycles after each accept -> order M I I I I M I I. Addresses 0x8000, 0x1000, 0x1200, 0x1400, 0x1600, 0x8040, 0x1800, 0x1A00; rreq_len 15 or 127; one frame_done pulse; busy low afterwards.
- NUM_RREQS_PER_CIMG=8, NUM_CIMG_RREQS_PER_MSG_RREQ=4 -> exactly 2 msg bursts; no msg after the 8th image burst.
- Hold rreq_ready=0 for 10 cycles -> rreq_valid, addr, len and is_msg stable for all 10 cycles; a single accept on release.
- Never pulse rdata_last -> exactly 4 handshakes, then valid stays 0. One rdata_last pulse -> one more request; a handshake coinciding with rdata_last leaves the count at 4.
- msg_infifo_can_accept=0 while msg pending -> no image requests issued. Raising it -> msg issued first.
- Reset asserted mid-ISSUE -> rreq_valid=0 and busy=0 next cycle, no frame_done. A new start restarts from the base addresses. rdata_last while idle -> err_rlast_underflow=1, sticky until reset.
